// File: rtl/cs_measure_if.sv
// cs_measure_if: sample input stream and measurement output stream of cs_measure
interface cs_measure_if #(parameter int ACC_W = 16);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic             out_ready;
  logic             frame_done;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, frame_done);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, frame_done);
endinterface

// File: rtl/cs_measure.sv
// cs_measure: compressive-sensing y = Phi*x with an LFSR-generated +/-1 Bernoulli matrix
module cs_measure #(
  parameter int          N_SAMPLES = 64,
  parameter int          M_MEAS    = 16,
  parameter int          ACC_W     = 16,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           frame_clr,
  cs_measure_if.slave   bus
);
  localparam int MW = M_MEAS > 1 ? $clog2(M_MEAS) : 1;
  localparam int NW = $clog2(N_SAMPLES);
  typedef enum logic [1:0] {COLLECT, MAC, DRAIN} state_t;
  state_t                  state;
  logic signed [ACC_W-1:0] acc [M_MEAS];
  logic [15:0]             lfsr;
  logic [NW-1:0]           n_cnt;
  logic [MW-1:0]           m_cnt;
  logic [7:0]              sample;
  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] sum;
  logic                    m_last;
  logic                    n_last;
  assign x      = ACC_W'(sample);
  assign sum    = lfsr[0] ? acc[m_cnt] - x : acc[m_cnt] + x;
  assign m_last = m_cnt == MW'(M_MEAS - 1);
  assign n_last = n_cnt == NW'(N_SAMPLES - 1);
  // Frame sequencer: collect one sample, spread it over all rows, drain results after the last sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      for (int i = 0; i < M_MEAS; i++) acc[i] <= '0;
      lfsr           <= SEED;
      n_cnt          <= '0;
      m_cnt          <= '0;
      sample         <= '0;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      if (frame_clr) begin
        state <= COLLECT;
        for (int i = 0; i < M_MEAS; i++) acc[i] <= '0;
        lfsr          <= SEED;
        n_cnt         <= '0;
        m_cnt         <= '0;
        bus.in_ready  <= 1'b1;
        bus.out_valid <= 1'b0;
      end else begin
        case (state)
          COLLECT: if (bus.in_valid) begin
            sample       <= bus.in_data;
            m_cnt        <= '0;
            bus.in_ready <= 1'b0;
            state        <= MAC;
          end
          MAC: begin
            acc[m_cnt] <= sum;
            lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            m_cnt      <= m_cnt + 1'b1;
            if (m_last && n_last) begin
              m_cnt         <= '0;
              bus.out_valid <= 1'b1;
              bus.out_data  <= m_cnt == '0 ? sum : acc[0];
              state         <= DRAIN;
            end else if (m_last) begin
              n_cnt        <= n_cnt + 1'b1;
              bus.in_ready <= 1'b1;
              state        <= COLLECT;
            end
          end
          DRAIN: if (bus.out_ready) begin
            if (m_last) begin
              for (int i = 0; i < M_MEAS; i++) acc[i] <= '0;
              lfsr           <= SEED;
              n_cnt          <= '0;
              m_cnt          <= '0;
              bus.out_valid  <= 1'b0;
              bus.in_ready   <= 1'b1;
              bus.frame_done <= 1'b1;
              state          <= COLLECT;
            end else begin
              m_cnt        <= m_cnt + 1'b1;
              bus.out_data <= acc[m_cnt + 1'b1];
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cs_measure.sv
// tb_cs_measure: randomized scoreboard bench for cs_measure against a matrix-product reference
module tb_cs_measure;
  localparam int          N    = 64;
  localparam int          M    = 16;
  localparam int          AW   = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk, rst_n, frame_clr;
  cs_measure_if #(.ACC_W(AW)) bus ();
  cs_measure #(.N_SAMPLES(N), .M_MEAS(M), .ACC_W(AW), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  bit seq [N*M];
  logic [AW-1:0] exp_q [$];
  logic [7:0] xs [N];
  int n_sent = 0;
  int pops = 0;
  bit fd_pending = 0;
  bit prev_stall = 0;
  logic [AW-1:0] prev_data;
  bit stall = 0;
  bit rnd_ready = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask
  // Reference: y[m] = sum_n Phi[m][n]*x[n], Phi entry -1 when sequence bit n*M+m is set
  task automatic push_frame();
    for (int m = 0; m < M; m++) begin
      int s = 0;
      for (int n = 0; n < N; n++) begin
        int v = int'(xs[n]);
        s += seq[n*M+m] ? -v : v;
      end
      exp_q.push_back(AW'(s));
    end
  endtask
  task automatic send(input logic [7:0] d);
    bit ok = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    else begin
      xs[n_sent] = d;
      n_sent++;
      if (n_sent == N) begin push_frame(); n_sent = 0; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
  endtask
  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) begin ok = 1; break; end
    end
    if (!ok) chk(name, 32'(exp_q.size()), 0);
  endtask
  // Output ready generator, applied after the driver's own updates in each cycle
  always @(posedge clk) begin
    #2;
    bus.out_ready = stall ? 1'b0 : rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
  end
  // Monitor: compares each accepted measurement against the scoreboard, plus hold and frame_done
  always @(negedge clk) begin
    if (rst_n) begin
      chk("frame_done", 32'(bus.frame_done), 32'(fd_pending));
      fd_pending = 0;
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 1);
        chk("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 32'(bus.out_data), 32'hFFFF_FFFF);
        else begin
          chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
          pops++;
          if (pops == M) begin pops = 0; fd_pending = 1; end
        end
      end
    end
  end
  initial begin
    logic [15:0] l = SEED;
    logic [7:0] rf [N];
    for (int k = 0; k < N*M; k++) begin
      seq[k] = l[0];
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    rst_n = 1'b0; frame_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    check_reset_state();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < N; n++) send(8'd0);
    wait_idle("drain_zero");
    for (int n = 0; n < N; n++) send(n == 0 ? 8'd1 : 8'd0);
    wait_idle("drain_impulse");
    for (int n = 0; n < N; n++) send(8'd255);
    wait_idle("drain_255");
    rnd_ready = 1;
    for (int n = 0; n < N; n++) rf[n] = 8'($urandom);
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < N; n++) send(rf[n]);
      wait_idle("drain_random");
    end
    rnd_ready = 0;
    for (int n = 0; n < N; n++) send(8'($urandom));
    stall = 1;
    for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    chk("stall_out_valid", 32'(bus.out_valid), 1);
    repeat (5) @(negedge clk);
    stall = 0;
    wait_idle("drain_stall");
    rnd_ready = 1;
    for (int n = 0; n < N; n++) begin
      send(8'($urandom));
      if (n == 10) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = 8'hEE;
        @(negedge clk);
        chk("mac_in_ready", 32'(bus.in_ready), 0);
        repeat (2) @(posedge clk);
        #1 bus.in_valid = 1'b0;
      end
    end
    wait_idle("drain_inject");
    for (int n = 0; n < 30; n++) send(8'($urandom));
    @(posedge clk); #1;
    frame_clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h55;
    @(posedge clk); #1;
    frame_clr = 1'b0; bus.in_valid = 1'b0;
    n_sent = 0;
    @(negedge clk);
    chk("clr_in_ready", 32'(bus.in_ready), 1);
    chk("clr_out_valid", 32'(bus.out_valid), 0);
    for (int n = 0; n < N; n++) send(8'($urandom));
    wait_idle("drain_after_clr");
    for (int n = 0; n < N; n++) send(8'($urandom));
    for (int i = 0; i < 200 && pops < 3; i++) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    pops = 0; fd_pending = 0; prev_stall = 0; n_sent = 0;
    check_reset_state();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < N; n++) send(8'($urandom));
    wait_idle("drain_after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
